mem_port_arbiter: RTL and testbench

// - Shares one single-ported synchronous word RAM between the core's instruction-fetch requester (I, read-only)
//   and its load/store requester (D, read/write with byte enables).
// - Sits between the cpu FSM and the unified memory that replaces the fetch-only rom.
// - Fair 2-way round-robin arbitration on conflict; one access in flight at a time; 2 cycles per access, back-to-back.

---
 rtl/risk_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// rtl/risk_pkg.sv - shared encodings for the memory port arbiter
package risk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // A new owner may be picked only when no access occupies the RAM port.
  function automatic logic is_arb_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_RESP);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-requester round-robin picker
module rr_arb2
  import risk_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic owner,
  output logic any
);

  always_comb begin
    any   = req_i | req_d;
    owner = OWN_I;
    if (req_i && req_d) begin
      owner = ~last;
    end else if (req_d) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported word RAM between fetch (I) and load/store (D)
module mem_port_arbiter
  import risk_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  state_t              state;
  state_t              state_nxt;
  owner_t              last_owner;
  owner_t              owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                pick_owner;
  logic                pick_any;
  logic                take;

  rr_arb2 u_arb (
    .req_i (i_req),
    .req_d (d_req),
    .last  (last_owner),
    .owner (pick_owner),
    .any   (pick_any)
  );

  assign take = is_arb_state(state) && pick_any;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = take ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   state_nxt = take ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= OWN_D;
      owner_q    <= OWN_I;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner_q <= owner_t'(pick_owner);
        if (pick_owner == OWN_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          be_q    <= d_be;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= i_addr;
          we_q    <= 1'b0;
          be_q    <= '0;
          wdata_q <= '0;
        end
      end
      // Fairness history moves only once an access is actually on the port.
      if (state == ST_ACCESS) begin
        last_owner <= owner_q;
      end
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (owner_q == OWN_D) begin
          d_gnt  = 1'b1;
          mem_we = we_q ? be_q : '0;
        end else begin
          i_gnt = 1'b1;
        end
      end
      ST_RESP: begin
        // Stores (including byte-enable-free ones) complete silently.
        if (!we_q) begin
          if (owner_q == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_rdata;
          end else begin
            i_rvalid = 1'b1;
            i_rdata  = mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [BW-1:0] d_be = '0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Environment RAM: read-first, data one cycle after mem_en.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic          gi;
    logic          gd;
    logic          rvi;
    logic          rvd;
    logic [DW-1:0] rdi;
    logic [DW-1:0] rdd;
    logic          en;
    logic [BW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wd_chk;
    logic          zero;
  } exp_t;

  // Reference: ea = expected outputs for the coming cycle, eb = the one after.
  exp_t          ea, eb;
  int            edge_no = 0;
  int            next_arb = 0;
  logic          last_d = 1'b1;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] last_i_rdata = '0;
  logic [DW-1:0] last_d_rdata = '0;
  int            gi_cnt = 0;
  int            gd_cnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, edge_no, got, exp);
    end
  endtask

  // Serial port: one access per two edges, the contender that went last yields.
  task automatic model_step();
    logic win_d;
    ea = eb;
    eb = '0;
    if (rst) begin
      ea      = '0;
      ea.zero = 1'b1;
      last_d  = 1'b1;
      next_arb = edge_no + 1;
    end else if (edge_no >= next_arb && (i_req || d_req)) begin
      win_d    = (i_req && d_req) ? ~last_d : d_req;
      last_d   = win_d;
      next_arb = edge_no + 2;
      ea.en    = 1'b1;
      if (win_d) begin
        ea.gd     = 1'b1;
        ea.addr   = d_addr;
        ea.wd_chk = 1'b1;
        ea.wdata  = d_wdata;
        if (d_we) begin
          ea.we = d_be;
          for (int b = 0; b < BW; b++) begin
            if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
          end
        end else begin
          eb.rvd = 1'b1;
          eb.rdd = ref_mem[d_addr];
        end
      end else begin
        ea.gi   = 1'b1;
        ea.addr = i_addr;
        eb.rvi  = 1'b1;
        eb.rdi  = ref_mem[i_addr];
      end
    end
    edge_no++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("i_gnt", i_gnt, ea.gi);
    chk("d_gnt", d_gnt, ea.gd);
    chk("i_rvalid", i_rvalid, ea.rvi);
    chk("d_rvalid", d_rvalid, ea.rvd);
    chk("i_rdata", i_rdata, ea.rdi);
    chk("d_rdata", d_rdata, ea.rdd);
    chk("mem_en", mem_en, ea.en);
    chk("mem_we", mem_we, ea.we);
    if (ea.en) chk("mem_addr", mem_addr, ea.addr);
    if (ea.wd_chk) chk("mem_wdata", mem_wdata, ea.wdata);
    if (ea.zero) begin
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
    end
    if (i_rvalid) last_i_rdata = i_rdata;
    if (d_rvalid) last_d_rdata = d_rdata;
    if (i_gnt) gi_cnt++;
    if (d_gnt) gd_cnt++;
    if (ea.gi) i_req = 1'b0;
    if (ea.gd) d_req = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_d(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    d_req = 1'b1; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    int got_at;
    for (int a = 0; a < (1 << AW); a++) begin
      ram[a]     = $urandom;
      ref_mem[a] = ram[a];
    end
    ram[5] = 32'h00500093;  ref_mem[5] = 32'h00500093;
    ram[3] = 32'h0;         ref_mem[3] = 32'h0;
    ram[9] = 32'h12345678;  ref_mem[9] = 32'h12345678;

    @(negedge clk);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(1);

    i_req = 1'b1; i_addr = 7'h05;
    steps(3);
    chk("fetch5", last_i_rdata, 32'h00500093);

    set_d(1'b1, 4'b0011, 7'd3, 32'hAABBCCDD);
    steps(3);
    set_d(1'b0, 4'b0000, 7'd3, 32'h0);
    steps(3);
    chk("load3", last_d_rdata, 32'h0000CCDD);

    gi_cnt = 0; gd_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (!i_req) begin i_req = 1'b1; i_addr = AW'($urandom); end
      if (!d_req) set_d(1'b0, 4'b0, AW'($urandom), $urandom);
      step();
    end
    chk("alt_i_count", gi_cnt, 3);
    chk("alt_d_count", gd_cnt, 3);
    i_req = 1'b0; d_req = 1'b0;
    steps(3);

    for (int k = 0; k < 5; k++) begin
      if (!d_req) set_d(1'b0, 4'b0, AW'($urandom), $urandom);
      step();
    end
    i_req = 1'b1; i_addr = AW'($urandom);
    got_at = 0;
    for (int k = 1; k <= 8; k++) begin
      if (!d_req) set_d(1'b0, 4'b0, AW'($urandom), $urandom);
      step();
      if (i_gnt && got_at == 0) got_at = k;
    end
    chk("i_late_served", (got_at > 0 && got_at <= 4), 1'b1);
    i_req = 1'b0; d_req = 1'b0;
    steps(3);

    set_d(1'b1, 4'b0000, 7'd9, 32'hDEADBEEF);
    steps(3);
    set_d(1'b0, 4'b0000, 7'd9, 32'h0);
    steps(3);
    chk("be0_unchanged", last_d_rdata, 32'h12345678);

    i_req = 1'b1; i_addr = 7'h05;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(2);
    last_i_rdata = '0;
    i_req = 1'b1; i_addr = 7'h05;
    steps(3);
    chk("fetch_after_rst", last_i_rdata, 32'h00500093);

    for (int k = 0; k < 600; k++) begin
      if (!i_req && ($urandom_range(2) == 0)) begin
        i_req = 1'b1; i_addr = AW'($urandom);
      end
      if (!d_req && ($urandom_range(2) == 0)) begin
        set_d(1'($urandom), BW'($urandom), AW'($urandom), $urandom);
      end
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    steps(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
